// File: rtl/regex_pkg.sv
// Shared defaults for the regex matcher, the match recorder and the drain stage.
package regex_pkg;
    localparam int POS_W_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef logic [POS_W_DEF-1:0] pos_t;
endpackage

// File: rtl/match_fifo.sv
// Show-ahead synchronous FIFO; head entry is presented combinationally while not empty.
module match_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          pop_ok;
    logic          push_ok;

    // A pop frees the slot the push needs, so a full FIFO still accepts a write when popped.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + CW'(1);
        else if (!push_ok && pop_ok)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/match_recorder.sv
// Logs the symbol position of each matcher hit into a FIFO and keeps match/overflow status.
// Optional MATCH_DEDUP_EN: only the rising edge of match is treated as an event.
module match_recorder
    import regex_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sym_valid,
    input  logic             match,
    input  logic             rd_en,
    output logic [POS_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] match_count
);
    logic [POS_W-1:0] pos_cnt;
    logic [POS_W-1:0] pos_rec;
    logic             evt;
    logic             drop;
    logic             empty;

    // The symbol accepted this cycle is the one the match belongs to.
    assign pos_rec = (sym_valid && (pos_cnt != '1)) ? pos_cnt + POS_W'(1) : pos_cnt;

`ifdef MATCH_DEDUP_EN
    logic match_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            match_q <= 1'b0;
        else if (clear)
            match_q <= 1'b0;
        else
            match_q <= match;
    end

    assign evt = match && !match_q;
`else
    assign evt = match;
`endif

    // Full implies not empty, so rd_en alone guarantees the pop frees a slot.
    assign drop = evt && full && !rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_cnt     <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            pos_cnt     <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            pos_cnt <= pos_rec;
            if (evt && (match_count != '1))
                match_count <= match_count + CNT_W'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end

    match_fifo #(
        .W     (POS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (evt),
        .pop   (rd_en),
        .wdata (pos_rec),
        .rdata (rd_data),
        .full  (full),
        .empty (empty)
    );

    assign rd_valid = !empty;
endmodule

// File: tb/tb_match_recorder.sv
// Scoreboard bench for match_recorder: expected FIFO entries are queued by the stimulus
// and popped by a monitor whenever the DUT head is consumed.
module tb_match_recorder;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        sym_valid;
    logic        match;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        overflow;
    logic [15:0] match_count;

    logic        sym2;
    logic        match2;
    logic        rd_en2;
    logic [3:0]  rd_data2;
    logic        rd_valid2;
    logic        full2;
    logic        overflow2;
    logic [15:0] match_count2;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    match_recorder dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .sym_valid   (sym_valid),
        .match       (match),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .overflow    (overflow),
        .match_count (match_count)
    );

    match_recorder #(.POS_W(4)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .sym_valid   (sym2),
        .match       (match2),
        .rd_en       (rd_en2),
        .rd_data     (rd_data2),
        .rd_valid    (rd_valid2),
        .full        (full2),
        .overflow    (overflow2),
        .match_count (match_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must deliver the oldest expected entry.
    always @(negedge clk) begin
        if (reset && rd_en && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_pop: got %0d expected no entry", rd_data);
            end else begin
                int unsigned e;
                e = exp_q.pop_front();
                if (32'(rd_data) != e) begin
                    errors++;
                    $display("FAIL fifo_pop: got %0d expected %0d", rd_data, e);
                end
            end
        end
    end

    task automatic cyc(input logic sv, input logic m, input logic re);
        sym_valid = sv;
        match     = m;
        rd_en     = re;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        clear = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        sym_valid = 1'b0;
        match     = 1'b0;
        rd_en     = 1'b1;
        while (rd_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        rd_en = 1'b0;
        check({name, "_drained"}, 32'(rd_valid), 32'd0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({name, "_rd_data"}, 32'(rd_data), 32'd0);
        check({name, "_full"}, 32'(full), 32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'd0);
        check({name, "_count"}, 32'(match_count), 32'd0);
    endtask

    // Isolated matches: a symbol with match, then a gap cycle so edge detection sees each one.
    task automatic fill(input int n, input bit track);
        for (int k = 1; k <= n; k++) begin
            if (track)
                exp_q.push_back(k);
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; sym_valid = 1'b0; match = 1'b0; rd_en = 1'b0;
        sym2 = 1'b0; match2 = 1'b0; rd_en2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check_idle("reset");

        // Basic logging: matches on symbols 4 and 19.
        for (int i = 1; i <= 20; i++) begin
            if (i == 4 || i == 19)
                exp_q.push_back(i);
            cyc(1'b1, (i == 4 || i == 19), 1'b0);
        end
        check("basic_count", 32'(match_count), 32'd2);
        check("basic_overflow", 32'(overflow), 32'd0);
        drain("basic");

        // Clear mid-run, with a match in the clear cycle itself.
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        clear = 1'b0;
        check_idle("clear");
        exp_q.push_back(1);
        cyc(1'b1, 1'b1, 1'b0);
        check("clear_restart_count", 32'(match_count), 32'd1);
        drain("clear");

        // Overflow: 10 matches, no reads.
        do_clear();
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8)
                exp_q.push_back(k);
            cyc(1'b1, 1'b1, 1'b0);
            if (k == 7) check("ovf_full_at7", 32'(full), 32'd0);
            if (k == 8) check("ovf_full_at8", 32'(full), 32'd1);
            if (k == 8) check("ovf_flag_at8", 32'(overflow), 32'd0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(match_count), 32'd10);
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop in the same cycle while full.
        do_clear();
        fill(8, 1'b1);
        exp_q.push_back(9);
        cyc(1'b1, 1'b1, 1'b1);
        rd_en = 1'b0;
        check("pp_full", 32'(full), 32'd1);
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_count", 32'(match_count), 32'd9);
        drain("pp");

        // Push and pop in the same cycle while empty.
        do_clear();
        exp_q.push_back(1);
        cyc(1'b1, 1'b1, 1'b1);
        rd_en = 1'b0;
        check("pe_valid", 32'(rd_valid), 32'd1);
        check("pe_data", 32'(rd_data), 32'd1);
        drain("pe");

        // Match before any symbol records 0; match without a symbol records the last position.
        do_clear();
        exp_q.push_back(0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        exp_q.push_back(2);
        cyc(1'b0, 1'b1, 1'b0);
        check("nosym_count", 32'(match_count), 32'd2);
        drain("nosym");

        // Match held high over symbols 5..7.
        do_clear();
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        exp_q.push_back(5);
`ifndef MATCH_DEDUP_EN
        exp_q.push_back(6);
        exp_q.push_back(7);
`endif
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
`ifdef MATCH_DEDUP_EN
        check("dedup_count", 32'(match_count), 32'd1);
`else
        check("dedup_count", 32'(match_count), 32'd3);
`endif
        drain("dedup");

        // Position saturation on the 4-bit instance.
        do_clear();
        for (int i = 1; i <= 20; i++) begin
            sym2   = 1'b1;
            match2 = (i == 20);
            @(posedge clk);
            #1;
        end
        sym2 = 1'b0; match2 = 1'b0;
        check("sat_valid", 32'(rd_valid2), 32'd1);
        check("sat_pos", 32'(rd_data2), 32'd15);
        check("sat_count", 32'(match_count2), 32'd1);

        // Async reset mid-operation discards entries without a clock edge.
        do_clear();
        fill(3, 1'b0);
        check("pre_rst_valid", 32'(rd_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check("post_rst_valid", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
